// File: rtl/dma_ring_wr_desc_gen.sv
// Ring write-descriptor generator: issues one slot-sized write descriptor per free
// ring slot, tracks in-flight descriptors and queues their completions in order.
module dma_ring_wr_desc_gen #(
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int LEN_WIDTH       = 20,
    parameter int TAG_WIDTH       = 8,
    parameter int PTR_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      ring_reset,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [3:0]                cfg_log_ring_size,
    input  logic [4:0]                cfg_log_slot_size,
    input  logic [PTR_WIDTH:0]        host_cons_ptr,
    output logic [AXI_ADDR_WIDTH-1:0] m_axis_write_desc_addr,
    output logic [LEN_WIDTH-1:0]      m_axis_write_desc_len,
    output logic [TAG_WIDTH-1:0]      m_axis_write_desc_tag,
    output logic                      m_axis_write_desc_valid,
    input  logic                      m_axis_write_desc_ready,
    input  logic [LEN_WIDTH-1:0]      s_axis_write_desc_status_len,
    input  logic [TAG_WIDTH-1:0]      s_axis_write_desc_status_tag,
    input  logic [7:0]                s_axis_write_desc_status_id,
    input  logic                      s_axis_write_desc_status_user,
    input  logic                      s_axis_write_desc_status_valid,
    output logic [PTR_WIDTH:0]        m_axis_cpl_ptr,
    output logic [LEN_WIDTH-1:0]      m_axis_cpl_len,
    output logic [7:0]                m_axis_cpl_id,
    output logic                      m_axis_cpl_user,
    output logic                      m_axis_cpl_valid,
    input  logic                      m_axis_cpl_ready,
    output logic [PTR_WIDTH:0]        head_ptr,
    output logic [PTR_WIDTH:0]        cpl_ptr,
    output logic                      busy,
    output logic                      status_err
);

    localparam int PW   = PTR_WIDTH + 1;
    localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FA_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FD   = 2 ** FA_W;

    localparam logic [PW:0]          SLOT_ONE = 1;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = 1;

    typedef enum logic [0:0] {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [PW-1:0]        ptr;
        logic [LEN_WIDTH-1:0] len;
        logic [7:0]           id;
        logic                 user;
    } cpl_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             cplp_q, cplp_d;
    logic [OW-1:0]             outst_q, outst_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic                      err_q, err_d;
    logic [FA_W:0]             wr_q, wr_d;
    logic [FA_W:0]             rd_q, rd_d;
    cpl_t                      mem_q [FD];
    cpl_t                      head_entry;

    logic [PW-1:0]             ring_mask;
    logic [PW-1:0]             head_idx;
    logic [PW-1:0]             occupancy;
    logic                      ring_free;
    logic                      can_issue;
    logic                      desc_hs;
    logic                      cpl_hs;
    logic                      fifo_nempty;
    logic                      ring_clear;
    logic [AXI_ADDR_WIDTH-1:0] slot_off;

    // Occupancy is measured against the host consumer pointer with full wrap arithmetic.
    assign ring_mask   = ~({PW{1'b1}} << cfg_log_ring_size);
    assign head_idx    = head_q & ring_mask;
    assign occupancy   = head_q - host_cons_ptr;
    assign ring_free   = {1'b0, occupancy} < (SLOT_ONE << cfg_log_ring_size);
    assign slot_off    = AXI_ADDR_WIDTH'(head_idx) << cfg_log_slot_size;
    assign can_issue   = enable && ring_free && (outst_q < OW'(MAX_OUTSTANDING));
    assign fifo_nempty = (wr_q != rd_q);
    assign desc_hs     = (state_q == ISSUE) && m_axis_write_desc_ready;
    assign cpl_hs      = fifo_nempty && m_axis_cpl_ready;
    assign busy        = (state_q == ISSUE) || (outst_q != '0);
    assign ring_clear  = ring_reset && !enable && !busy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                // Fields are latched on entry so they hold even if config or enable move.
                if (can_issue) begin
                    state_d = ISSUE;
                    addr_d  = cfg_base_addr + slot_off;
                    len_d   = LEN_ONE << cfg_log_slot_size;
                    tag_d   = head_q[TAG_WIDTH-1:0];
                end
            end
            ISSUE: begin
                if (desc_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        cplp_d  = cplp_q;
        outst_d = outst_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        err_d   = s_axis_write_desc_status_valid &&
                  (s_axis_write_desc_status_tag != cplp_q[TAG_WIDTH-1:0]);
        case ({desc_hs, cpl_hs})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase
        if (desc_hs) begin
            head_d = head_q + PW'(1);
        end
        if (s_axis_write_desc_status_valid) begin
            cplp_d = cplp_q + PW'(1);
            wr_d   = wr_q + (FA_W+1)'(1);
        end
        if (cpl_hs) begin
            rd_d = rd_q + (FA_W+1)'(1);
        end
        if (ring_clear) begin
            head_d = '0;
            cplp_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            cplp_q  <= '0;
            outst_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cplp_q  <= cplp_d;
            outst_q <= outst_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Completion storage needs no reset: the read side is gated by the pointers.
    always_ff @(posedge clk) begin
        if (s_axis_write_desc_status_valid) begin
            mem_q[wr_q[FA_W-1:0]] <= '{ptr:  cplp_q,
                                       len:  s_axis_write_desc_status_len,
                                       id:   s_axis_write_desc_status_id,
                                       user: s_axis_write_desc_status_user};
        end
    end

    assign head_entry = mem_q[rd_q[FA_W-1:0]];

    assign m_axis_write_desc_addr  = addr_q;
    assign m_axis_write_desc_len   = len_q;
    assign m_axis_write_desc_tag   = tag_q;
    assign m_axis_write_desc_valid = (state_q == ISSUE);

    assign m_axis_cpl_valid = fifo_nempty;
    assign m_axis_cpl_ptr   = fifo_nempty ? head_entry.ptr  : '0;
    assign m_axis_cpl_len   = fifo_nempty ? head_entry.len  : '0;
    assign m_axis_cpl_id    = fifo_nempty ? head_entry.id   : '0;
    assign m_axis_cpl_user  = fifo_nempty ? head_entry.user : 1'b0;

    assign head_ptr   = head_q;
    assign cpl_ptr    = cplp_q;
    assign status_err = err_q;

endmodule

// File: tb/tb_dma_ring_wr_desc_gen.sv
// Directed bench for dma_ring_wr_desc_gen with queue-based scoreboards for
// descriptors and completions.
module tb_dma_ring_wr_desc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ring_reset;
    logic [15:0] cfg_base_addr;
    logic [3:0]  cfg_log_ring_size;
    logic [4:0]  cfg_log_slot_size;
    logic [8:0]  host_cons_ptr;
    logic [15:0] m_axis_write_desc_addr;
    logic [19:0] m_axis_write_desc_len;
    logic [7:0]  m_axis_write_desc_tag;
    logic        m_axis_write_desc_valid;
    logic        m_axis_write_desc_ready;
    logic [19:0] st_len;
    logic [7:0]  st_tag;
    logic [7:0]  st_id;
    logic        st_user;
    logic        st_valid;
    logic [8:0]  m_axis_cpl_ptr;
    logic [19:0] m_axis_cpl_len;
    logic [7:0]  m_axis_cpl_id;
    logic        m_axis_cpl_user;
    logic        m_axis_cpl_valid;
    logic        m_axis_cpl_ready;
    logic [8:0]  head_ptr;
    logic [8:0]  cpl_ptr;
    logic        busy;
    logic        status_err;

    typedef struct {
        logic [15:0] addr;
        logic [19:0] len;
        logic [7:0]  tag;
    } desc_exp_t;

    typedef struct {
        logic [8:0]  ptr;
        logic [19:0] len;
        logic [7:0]  id;
        logic        user;
    } cpl_exp_t;

    desc_exp_t  exp_desc[$];
    cpl_exp_t   exp_cpl[$];
    int         checks = 0;
    int         errors = 0;
    logic [8:0] m_cpl = '0;

    dma_ring_wr_desc_gen dut (
        .clk                            (clk),
        .rst                            (rst),
        .enable                         (enable),
        .ring_reset                     (ring_reset),
        .cfg_base_addr                  (cfg_base_addr),
        .cfg_log_ring_size              (cfg_log_ring_size),
        .cfg_log_slot_size              (cfg_log_slot_size),
        .host_cons_ptr                  (host_cons_ptr),
        .m_axis_write_desc_addr         (m_axis_write_desc_addr),
        .m_axis_write_desc_len          (m_axis_write_desc_len),
        .m_axis_write_desc_tag          (m_axis_write_desc_tag),
        .m_axis_write_desc_valid        (m_axis_write_desc_valid),
        .m_axis_write_desc_ready        (m_axis_write_desc_ready),
        .s_axis_write_desc_status_len   (st_len),
        .s_axis_write_desc_status_tag   (st_tag),
        .s_axis_write_desc_status_id    (st_id),
        .s_axis_write_desc_status_user  (st_user),
        .s_axis_write_desc_status_valid (st_valid),
        .m_axis_cpl_ptr                 (m_axis_cpl_ptr),
        .m_axis_cpl_len                 (m_axis_cpl_len),
        .m_axis_cpl_id                  (m_axis_cpl_id),
        .m_axis_cpl_user                (m_axis_cpl_user),
        .m_axis_cpl_valid               (m_axis_cpl_valid),
        .m_axis_cpl_ready               (m_axis_cpl_ready),
        .head_ptr                       (head_ptr),
        .cpl_ptr                        (cpl_ptr),
        .busy                           (busy),
        .status_err                     (status_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_head(input logic [8:0] v, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (head_ptr === v) break;
            tick(1);
        end
        check(tag, 64'(head_ptr), 64'(v));
    endtask

    task automatic wait_desc_valid(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (m_axis_write_desc_valid === 1'b1) break;
            tick(1);
        end
        check(tag, 64'(m_axis_write_desc_valid), 64'd1);
    endtask

    task automatic wait_cpl_drain(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (exp_cpl.size() == 0) break;
            tick(1);
        end
        check(tag, 64'(exp_cpl.size()), 64'd0);
    endtask

    task automatic push_desc(input logic [15:0] addr, input logic [7:0] tag);
        exp_desc.push_back('{addr: addr, len: 20'd256, tag: tag});
    endtask

    // One status beat; the error flag must reflect a tag/cpl_ptr mismatch one cycle later.
    task automatic send_status(input logic [7:0] tag, input logic [7:0] id,
                               input logic user, input bit push);
        logic exp_err;
        st_len   = 20'(256 + id);
        st_tag   = tag;
        st_id    = id;
        st_user  = user;
        st_valid = 1'b1;
        if (push) exp_cpl.push_back('{ptr: m_cpl, len: 20'(256 + id), id: id, user: user});
        exp_err = (tag != m_cpl[7:0]);
        m_cpl   = m_cpl + 9'd1;
        tick(1);
        st_valid = 1'b0;
        check("status_err", 64'(status_err), 64'(exp_err));
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && m_axis_write_desc_valid && m_axis_write_desc_ready) begin
            checks++;
            assert (exp_desc.size() != 0) else begin
                errors++;
                $error("FAIL desc_unexpected observed tag=%0h expected=none", m_axis_write_desc_tag);
            end
            if (exp_desc.size() != 0) begin
                desc_exp_t d;
                d = exp_desc.pop_front();
                check("desc_addr", 64'(m_axis_write_desc_addr), 64'(d.addr));
                check("desc_len", 64'(m_axis_write_desc_len), 64'(d.len));
                check("desc_tag", 64'(m_axis_write_desc_tag), 64'(d.tag));
            end
        end
        if (rst === 1'b1 && m_axis_cpl_valid && m_axis_cpl_ready) begin
            checks++;
            assert (exp_cpl.size() != 0) else begin
                errors++;
                $error("FAIL cpl_unexpected observed ptr=%0h expected=none", m_axis_cpl_ptr);
            end
            if (exp_cpl.size() != 0) begin
                cpl_exp_t c;
                c = exp_cpl.pop_front();
                check("cpl_ptr", 64'(m_axis_cpl_ptr), 64'(c.ptr));
                check("cpl_len", 64'(m_axis_cpl_len), 64'(c.len));
                check("cpl_id", 64'(m_axis_cpl_id), 64'(c.id));
                check("cpl_user", 64'(m_axis_cpl_user), 64'(c.user));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_desc_valid"}, 64'(m_axis_write_desc_valid), 64'd0);
        check({tag, "_desc_addr"}, 64'(m_axis_write_desc_addr), 64'd0);
        check({tag, "_desc_len"}, 64'(m_axis_write_desc_len), 64'd0);
        check({tag, "_desc_tag"}, 64'(m_axis_write_desc_tag), 64'd0);
        check({tag, "_cpl_valid"}, 64'(m_axis_cpl_valid), 64'd0);
        check({tag, "_cpl_ptr_out"}, 64'(m_axis_cpl_ptr), 64'd0);
        check({tag, "_cpl_len_out"}, 64'(m_axis_cpl_len), 64'd0);
        check({tag, "_cpl_id_out"}, 64'(m_axis_cpl_id), 64'd0);
        check({tag, "_cpl_user_out"}, 64'(m_axis_cpl_user), 64'd0);
        check({tag, "_head"}, 64'(head_ptr), 64'd0);
        check({tag, "_cplp"}, 64'(cpl_ptr), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_status_err"}, 64'(status_err), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        ring_reset = 1'b0;
        cfg_base_addr = 16'h1000;
        cfg_log_ring_size = 4'd2;
        cfg_log_slot_size = 5'd8;
        host_cons_ptr = '0;
        m_axis_write_desc_ready = 1'b1;
        m_axis_cpl_ready = 1'b1;
        st_len = '0;
        st_tag = '0;
        st_id = '0;
        st_user = 1'b0;
        st_valid = 1'b0;
        tick(3);
        check_reset_outputs("rst0");

        // Four slots issue back to back, then the ring/outstanding limit stalls issue.
        for (int i = 0; i < 4; i++) push_desc(16'h1000 + 16'(i * 256), 8'(i));
        rst = 1'b1;
        enable = 1'b1;
        wait_head(9'd4, 40, "fill_head");
        tick(6);
        check("fill_stall_valid", 64'(m_axis_write_desc_valid), 64'd0);
        check("fill_stall_head", 64'(head_ptr), 64'd4);
        check("fill_busy", 64'(busy), 64'd1);

        for (int i = 0; i < 4; i++) send_status(8'(i), 8'(8'h10 + i), 1'(i), 1'b1);
        wait_cpl_drain(20, "cpl0_drain");
        tick(4);
        check("full_ring_head", 64'(head_ptr), 64'd4);
        check("full_ring_valid", 64'(m_axis_write_desc_valid), 64'd0);
        check("cplp_after4", 64'(cpl_ptr), 64'd4);

        for (int i = 0; i < 4; i++) push_desc(16'h1000 + 16'(i * 256), 8'(4 + i));
        host_cons_ptr = 9'd4;
        wait_head(9'd8, 40, "second_lap_head");
        tick(6);
        check("second_lap_stall", 64'(m_axis_write_desc_valid), 64'd0);

        // Completions back up with cpl_ready low; issue must wait on the first pop.
        host_cons_ptr = 9'd8;
        m_axis_cpl_ready = 1'b0;
        for (int i = 4; i < 8; i++) send_status(8'(i), 8'(8'h20 + i), 1'(i), 1'b1);
        tick(4);
        check("bp_head", 64'(head_ptr), 64'd8);
        check("bp_desc_valid", 64'(m_axis_write_desc_valid), 64'd0);
        check("bp_cpl_valid", 64'(m_axis_cpl_valid), 64'd1);
        for (int i = 0; i < 4; i++) push_desc(16'h1000 + 16'(i * 256), 8'(8 + i));
        m_axis_cpl_ready = 1'b1;
        wait_head(9'd12, 60, "bp_head_after");
        wait_cpl_drain(20, "cpl1_drain");
        tick(6);
        check("bp_final_head", 64'(head_ptr), 64'd12);
        check("bp_final_valid", 64'(m_axis_write_desc_valid), 64'd0);
        check("bp_final_busy", 64'(busy), 64'd1);

        enable = 1'b0;
        ring_reset = 1'b1;
        tick(1);
        ring_reset = 1'b0;
        check("rr_busy_head", 64'(head_ptr), 64'd12);
        check("rr_busy_cplp", 64'(cpl_ptr), 64'd8);

        for (int i = 8; i < 12; i++) send_status(8'(i), 8'(8'h30 + i), 1'(i), 1'b1);
        wait_cpl_drain(20, "cpl2_drain");
        tick(2);
        check("idle_busy", 64'(busy), 64'd0);
        ring_reset = 1'b1;
        tick(1);
        ring_reset = 1'b0;
        check("rr_idle_head", 64'(head_ptr), 64'd0);
        check("rr_idle_cplp", 64'(cpl_ptr), 64'd0);
        m_cpl = '0;
        host_cons_ptr = '0;

        // A wrong tag at cpl_ptr=2 flags an error but the entry still completes.
        for (int i = 0; i < 4; i++) push_desc(16'h1000 + 16'(i * 256), 8'(i));
        enable = 1'b1;
        wait_head(9'd4, 40, "err_fill_head");
        send_status(8'd0, 8'h40, 1'b0, 1'b1);
        send_status(8'd1, 8'h41, 1'b1, 1'b1);
        send_status(8'd7, 8'h42, 1'b0, 1'b1);
        send_status(8'd3, 8'h43, 1'b1, 1'b1);
        wait_cpl_drain(20, "cpl3_drain");
        tick(1);
        check("err_cleared", 64'(status_err), 64'd0);

        // Held descriptor: fields stay put while ready is low, even after enable drops.
        m_axis_write_desc_ready = 1'b0;
        push_desc(16'h1000, 8'd4);
        host_cons_ptr = 9'd4;
        wait_desc_valid(10, "hold_valid_rise");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) enable = 1'b0;
            check("hold_valid", 64'(m_axis_write_desc_valid), 64'd1);
            check("hold_addr", 64'(m_axis_write_desc_addr), 64'h1000);
            check("hold_tag", 64'(m_axis_write_desc_tag), 64'd4);
            tick(1);
        end
        m_axis_write_desc_ready = 1'b1;
        wait_head(9'd5, 10, "hold_head");
        tick(4);
        check("hold_no_reissue", 64'(m_axis_write_desc_valid), 64'd0);
        check("hold_head_final", 64'(head_ptr), 64'd5);

        // Reset mid-transfer with two buffered completions and a pending descriptor.
        m_axis_cpl_ready = 1'b0;
        send_status(8'd4, 8'h50, 1'b1, 1'b0);
        push_desc(16'h1100, 8'd5);
        enable = 1'b1;
        wait_head(9'd6, 20, "mid_head6");
        m_axis_write_desc_ready = 1'b0;
        send_status(8'd5, 8'h51, 1'b0, 1'b0);
        wait_desc_valid(10, "mid_desc_valid");
        check("mid_cpl_valid", 64'(m_axis_cpl_valid), 64'd1);
        enable = 1'b0;
        rst = 1'b0;
        tick(1);
        check_reset_outputs("rst1");
        rst = 1'b1;
        tick(2);
        check("rst1_after_release", 64'(m_axis_cpl_valid), 64'd0);
        check("desc_queue_empty", 64'(exp_desc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
